// File: rtl/pdm_demod.sv
// -----------------------------------------------------------------------------
// pdm_demod
//
// Recovers multi-bit density samples from a 1-bit pulse-density-modulated
// stream. It uses a 3rd-order CIC decimator with ratio R = 2^DECIM_LOG2 and
// saturates the output.
//
// The CIC structure has three parts:
//   * Three integrators run at the input rate. They wrap modulo 2^W, with
//     W = OUT_WIDTH + 1.
//   * A decimation counter raises a one-cycle strobe when a frame of R
//     accepted samples is complete.
//   * A three-stage comb pipeline, followed by the saturating output register,
//     turns that strobe into a dout_valid pulse 4 cycles later.
//
// Ports:
//   clk        : single clock, rising edge
//   resetn     : asynchronous active-low reset of all state
//   clear      : synchronous flush of all filter state (priority over input)
//   din        : PDM bit (1 -> +1, 0 -> 0)
//   din_valid  : din accepted on rising edges where this is high
//   dout       : unsigned decimated density sample, held between pulses
//   dout_valid : one-cycle pulse marking a new dout
//
// Optional feature (macro PDM_DEMOD_SETTLE_EN):
//   When defined, a 2-bit settle counter suppresses dout_valid for the first
//   three outputs after reset/clear. Those outputs are filter fill. dout still
//   updates on those outputs.
// -----------------------------------------------------------------------------
module pdm_demod #(
    parameter int DECIM_LOG2 = 4,
    parameter int OUT_WIDTH  = 3 * DECIM_LOG2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 din,
    input  logic                 din_valid,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid
);

    // One guard bit above OUT_WIDTH holds the full-scale value R^3 = 2^OUT_WIDTH.
    localparam int W = OUT_WIDTH + 1;

    // c3 lies in 0..R^3. Only R^3 sets the top bit, so that bit alone
    // selects the clip value.
    function automatic logic [OUT_WIDTH-1:0] sat(input logic [W-1:0] v);
        if (v[W-1]) begin
            return {OUT_WIDTH{1'b1}};
        end
        return v[OUT_WIDTH-1:0];
    endfunction

    logic [W-1:0]          i1_p0, i2_p0, i3_p0;
    logic [DECIM_LOG2-1:0] cnt_p0;
    logic                  vld_p0;
    logic [W-1:0]          c1_p1, z1_p1;
    logic                  vld_p1;
    logic [W-1:0]          c2_p2, z2_p2;
    logic                  vld_p2;
    logic [W-1:0]          c3_p3, z3_p3;
    logic                  vld_p3;
    logic                  out_en;

    // ---- stage p0: integrators and decimation counter (input rate) ----
    // Each integrator reads the previous stage's registered value. The
    // counter wraps naturally at R because it is exactly DECIM_LOG2 bits wide.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i1_p0  <= '0;
            i2_p0  <= '0;
            i3_p0  <= '0;
            cnt_p0 <= '0;
            vld_p0 <= 1'b0;
        end else if (clear) begin
            i1_p0  <= '0;
            i2_p0  <= '0;
            i3_p0  <= '0;
            cnt_p0 <= '0;
            vld_p0 <= 1'b0;
        end else if (din_valid) begin
            i1_p0  <= i1_p0 + {{(W-1){1'b0}}, din};
            i2_p0  <= i2_p0 + i1_p0;
            i3_p0  <= i3_p0 + i2_p0;
            cnt_p0 <= cnt_p0 + 1'b1;
            vld_p0 <= (cnt_p0 == {DECIM_LOG2{1'b1}});
        end else begin
            vld_p0 <= 1'b0;
        end
    end

    // ---- stage p1: first comb ----
    // i3 may already be advancing with the next frame's samples. This stage
    // still reads the value registered at the frame's last accepting edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c1_p1  <= '0;
            z1_p1  <= '0;
            vld_p1 <= 1'b0;
        end else if (clear) begin
            c1_p1  <= '0;
            z1_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                c1_p1 <= i3_p0 - z1_p1;
                z1_p1 <= i3_p0;
            end
        end
    end

    // ---- stage p2: second comb ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c2_p2  <= '0;
            z2_p2  <= '0;
            vld_p2 <= 1'b0;
        end else if (clear) begin
            c2_p2  <= '0;
            z2_p2  <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                c2_p2 <= c1_p1 - z2_p2;
                z2_p2 <= c1_p1;
            end
        end
    end

    // ---- stage p3: third comb (modulo-2^W result is exact) ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c3_p3  <= '0;
            z3_p3  <= '0;
            vld_p3 <= 1'b0;
        end else if (clear) begin
            c3_p3  <= '0;
            z3_p3  <= '0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                c3_p3 <= c2_p2 - z3_p3;
                z3_p3 <= c2_p2;
            end
        end
    end

`ifdef PDM_DEMOD_SETTLE_EN
    // The first three outputs after reset/clear are filter fill. The counter
    // saturates at 3 and then enables every later pulse.
    logic [1:0] settle_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            settle_cnt <= 2'd0;
        end else if (clear) begin
            settle_cnt <= 2'd0;
        end else if (vld_p3 && (settle_cnt != 2'd3)) begin
            settle_cnt <= settle_cnt + 2'd1;
        end
    end

    assign out_en = (settle_cnt == 2'd3);
`else
    assign out_en = 1'b1;
`endif

    // ---- stage p4: saturating output register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clear) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= vld_p3 && out_en;
            if (vld_p3) begin
                dout <= sat(c3_p3);
            end
        end
    end

endmodule

// File: tb/tb_pdm_demod.sv
// -----------------------------------------------------------------------------
// tb_pdm_demod
//
// Scoreboard bench for pdm_demod with DECIM_LOG2 = 4 (R = 16, 12-bit output).
//
// Reference model:
//   * Accepted input bits are stored per reset/clear epoch.
//   * The third integrator after n samples is i3[n] = sum_j x[j] * C(n-1-j, 2).
//   * A frame output is the third difference of i3 at frame boundaries,
//     spaced R apart, computed with plain 64-bit arithmetic and then
//     saturated.
//
// Checking:
//   * The driver pushes the expected value and the cycle it is due on.
//   * The monitor pops an entry on every dout_valid and compares value and
//     timing.
//   * Missed or unexpected pulses are reported as failures.
// -----------------------------------------------------------------------------
module tb_pdm_demod;

    localparam int DL    = 4;
    localparam int R     = 1 << DL;
    localparam int OW    = 3 * DL;
    localparam longint RCUBE = longint'(R) * R * R;
    localparam int SATV  = (1 << OW) - 1;
`ifdef PDM_DEMOD_SETTLE_EN
    localparam int SKIP  = 3;
`else
    localparam int SKIP  = 0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          clear = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic [OW-1:0] dout;
    logic          dout_valid;

    always #5 clk = ~clk;

    pdm_demod #(.DECIM_LOG2(DL)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t expq[$];
    bit   xs[$];
    int   frames = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;

    function automatic longint c2(longint a);
        return (a < 2) ? 64'd0 : a * (a - 1) / 2;
    endfunction

    // Output of frame k (1-based) in the current epoch. Inputs older than
    // 4 frames contribute zero, because their kernel terms form the third
    // difference of a quadratic.
    function automatic int model_frame(int k);
        longint y = 0;
        longint n = longint'(k) * R;
        int lo = (k - 4) * R;
        if (lo < 0) lo = 0;
        for (int j = lo; j < k * R; j++) begin
            if (xs[j]) begin
                y += c2(n - 1 - j) - 3 * c2(n - R - 1 - j)
                   + 3 * c2(n - 2 * R - 1 - j) - c2(n - 3 * R - 1 - j);
            end
        end
        return (y >= RCUBE) ? SATV : int'(y);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic epoch_reset();
        xs.delete();
        frames = 0;
        expq.delete();
    endtask

    // Drive one cycle. The next rising edge is edge number cyc+1. An output
    // is due 4 edges after the edge that accepts a frame's last sample.
    task automatic step(input bit v, input bit b);
        @(negedge clk);
        clear     = 1'b0;
        din_valid = v;
        din       = b;
        if (v) begin
            xs.push_back(b);
            if ((xs.size() % R) == 0) begin
                frames++;
                if (frames > SKIP) expq.push_back('{model_frame(frames), cyc + 1 + 4});
            end
        end
    endtask

    // One-cycle clear. The sample presented on that edge is discarded.
    task automatic do_clear();
        @(negedge clk);
        clear     = 1'b1;
        din_valid = 1'b1;
        din       = 1'b1;
        epoch_reset();
        @(negedge clk);
        clear     = 1'b0;
        din_valid = 1'b0;
        chk("clear_dout", int'(dout), 0);
        chk("clear_valid", int'(dout_valid), 0);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic async_reset();
        @(negedge clk);
        din_valid = 1'b0;
        #2 resetn = 1'b0;
        epoch_reset();
        #1;
        chk("areset_dout", int'(dout), 0);
        chk("areset_valid", int'(dout_valid), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (expq.size() > 0 && expq[0].due < cyc) begin
                mon_e = expq.pop_front();
                chk("missed_output", cyc, mon_e.due);
            end
            if (dout_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("out_time", cyc, mon_e.due);
                    chk("out_val", int'(dout), mon_e.val);
                end
            end
        end
    end

    initial begin
        bit b;
        repeat (3) @(negedge clk);
        chk("reset_dout", int'(dout), 0);
        chk("reset_valid", int'(dout_valid), 0);
        resetn = 1'b1;

        // All ones at full rate: saturates to 4095 once settled.
        repeat (8 * R) step(1'b1, 1'b1);

        // All zeros: every output 0, including fill.
        do_clear();
        repeat (6 * R) step(1'b1, 1'b0);

        // Alternating 1,0 at full rate, then every third cycle.
        do_clear();
        b = 1'b1;
        repeat (8 * R) begin
            step(1'b1, b);
            b = ~b;
        end
        for (int i = 0; i < 6 * R * 3; i++) begin
            if (i % 3 == 0) begin
                step(1'b1, b);
                b = ~b;
            end else begin
                step(1'b0, 1'b0);
            end
        end

        // Random density and random valid gaps.
        for (int i = 0; i < 12 * R * 2; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        // Long all-ones run: integrators wrap past 2^13 samples.
        do_clear();
        repeat (9000) step(1'b1, 1'b1);

        // Clear at sample 7 of a frame.
        while ((xs.size() % R) != 0) step(1'b1, 1'b1);
        repeat (7) step(1'b1, 1'b1);
        do_clear();
        repeat (5 * R) step(1'b1, 1'b1);

        // Async reset mid-frame, then random full-rate data.
        repeat (5) step(1'b1, 1'b1);
        async_reset();
        for (int i = 0; i < 6 * R; i++) begin
            step(1'b1, $urandom_range(0, 1) == 1);
        end

        // Drain: every pushed output must have appeared.
        repeat (12) step(1'b0, 1'b0);
        chk("drain_pending", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
